// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_multicycle_ctrl_if : control <-> datapath/memory bundle  (rev 1.0)  |
// +--------------------------------------------------------------------------+
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             reg_we;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             ext_op;
  logic [3:0]       state_o;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, state_o, trap,
           retired
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, state_o, trap,
           retired
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_multicycle_ctrl : multi-cycle MIPS control FSM            (rev 1.0) |
// +--------------------------------------------------------------------------+
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  mips_multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               trap_q;
  logic [CNT_W-1:0]   retired_cnt;
  logic               timeout_hit;
  logic               mem_state;
  logic               retire;

  logic               ctl_mem_req;
  logic               ctl_mem_we;
  logic               ctl_iord;
  logic               ctl_ir_we;
  logic               ctl_pc_we;
  logic [1:0]         ctl_pc_src;
  logic               ctl_reg_we;
  logic               ctl_reg_dst;
  logic               ctl_mem_to_reg;
  logic               ctl_alu_src_a;
  logic [1:0]         ctl_alu_src_b;
  logic [2:0]         ctl_alu_op;
  logic               ctl_ext_op;

  // The ALU decodes funct itself; the controller only carries it along.
  logic               unused_funct;
  assign unused_funct = ^bus.funct;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  always_comb begin
    state_next     = state;
    retire         = 1'b0;
    ctl_mem_req    = 1'b0;
    ctl_mem_we     = 1'b0;
    ctl_iord       = 1'b0;
    ctl_ir_we      = 1'b0;
    ctl_pc_we      = 1'b0;
    ctl_pc_src     = 2'b00;
    ctl_reg_we     = 1'b0;
    ctl_reg_dst    = 1'b0;
    ctl_mem_to_reg = 1'b0;
    ctl_alu_src_a  = 1'b0;
    ctl_alu_src_b  = 2'b00;
    ctl_alu_op     = ALU_ADD;
    ctl_ext_op     = 1'b0;

    case (state)
      S_FETCH: begin
        ctl_mem_req   = 1'b1;
        ctl_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ctl_ir_we  = 1'b1;
          ctl_pc_we  = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ctl_alu_src_b = 2'b11;
        ctl_ext_op    = 1'b1;
        case (bus.opcode)
          OP_RTYPE:                 state_next = S_R_EXE;
          OP_LW, OP_SW:             state_next = S_MEM_ADDR;
          OP_BEQ:                   state_next = S_BRANCH;
          OP_J:                     state_next = S_JUMP;
          OP_ADDIU, OP_ORI, OP_LUI: state_next = S_I_EXE;
          default:                  state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctl_alu_src_a = 1'b1;
        ctl_alu_src_b = 2'b10;
        ctl_ext_op    = 1'b1;
        state_next    = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctl_mem_req = 1'b1;
        ctl_iord    = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_MEM_WB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end
      S_MEM_WB: begin
        ctl_reg_we     = 1'b1;
        ctl_mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEM_WR: begin
        ctl_mem_req = 1'b1;
        ctl_mem_we  = 1'b1;
        ctl_iord    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end
      S_R_EXE: begin
        ctl_alu_src_a = 1'b1;
        ctl_alu_op    = ALU_FUNCT;
        state_next    = S_R_WB;
      end
      S_R_WB: begin
        ctl_reg_we  = 1'b1;
        ctl_reg_dst = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        ctl_alu_src_a = 1'b1;
        ctl_alu_op    = ALU_SUB;
        ctl_pc_src    = 2'b01;
        ctl_pc_we     = bus.alu_zero;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        ctl_pc_we  = 1'b1;
        ctl_pc_src = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_I_EXE: begin
        ctl_alu_src_a = 1'b1;
        ctl_alu_src_b = 2'b10;
        case (bus.opcode)
          OP_ORI:  ctl_alu_op = ALU_OR;
          OP_LUI:  ctl_alu_op = ALU_LUI;
          default: begin
            ctl_alu_op = ALU_ADD;
            ctl_ext_op = 1'b1;
          end
        endcase
        state_next = S_I_WB;
      end
      S_I_WB: begin
        ctl_reg_we = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      trap_q      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_state && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state_next == S_TRAP) begin
        trap_q <= 1'b1;
      end
      if (retire) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

  // Strobes are qualified by reset so an access aborted by reset drops at once.
  assign bus.mem_req    = ctl_mem_req & reset;
  assign bus.mem_we     = ctl_mem_we  & reset;
  assign bus.ir_we      = ctl_ir_we   & reset;
  assign bus.pc_we      = ctl_pc_we   & reset;
  assign bus.reg_we     = ctl_reg_we  & reset;
  assign bus.iord       = ctl_iord;
  assign bus.pc_src     = ctl_pc_src;
  assign bus.reg_dst    = ctl_reg_dst;
  assign bus.mem_to_reg = ctl_mem_to_reg;
  assign bus.alu_src_a  = ctl_alu_src_a;
  assign bus.alu_src_b  = ctl_alu_src_b;
  assign bus.alu_op     = ctl_alu_op;
  assign bus.ext_op     = ctl_ext_op;
  assign bus.state_o    = state;
  assign bus.trap       = trap_q;
  assign bus.retired    = retired_cnt;

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback states, with a request/ready handshake to a variable-latency unified memory. It replaces per-instruction combinational control: one instruction retires every 3–5 cycles plus memory wait cycles.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ready in any memory state before trapping; 0 disables the timeout.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0] (pass-through context only; ALU decodes it)
alu_zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe (qualified by mem_req)
iord  out  1  0=address from PC, 1=address from ALUOut
ir_we  out  1  load IR from memory read data
pc_we  out  1  load PC
pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
reg_we  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_op  out  3  000 ADD, 001 SUB, 010 FUNCT, 011 OR, 100 LUI
ext_op  out  1  0=zero-extend, 1=sign-extend
state_o  out  4  current state encoding (debug)
trap  out  1  sticky: illegal opcode or memory timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BRANCH=8, JUMP=9, I_EXE=10, I_WB=11, TRAP=12. Codes 13–15 go to TRAP.
- Reset (reset=0, async): state=FETCH, trap=0, retired=0, wait counter=0. All outputs are Moore/Mealy functions of state; in FETCH with mem_ready=0, only mem_req=1 and alu_src_b=01.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD. While mem_ready=0, hold. When mem_ready=1, same cycle: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXE
  - 100011/101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001001/001101/001111 → I_EXE
  - anything else → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, ADD. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_req=1, iord=1; hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1; retire; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then retire and go to FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. R_WB: reg_we=1, reg_dst=1, mem_to_reg=0; retire; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=alu_zero; retire; go to FETCH.
- JUMP: pc_we=1, pc_src=10; retire; go to FETCH.
- I_EXE: alu_src_a=1, alu_src_b=10. Per opcode:
  - addiu: ext_op=1, ADD
  - ori: ext_op=0, OR
  - lui: ext_op=0, LUI
- I_WB: reg_we=1, reg_dst=0, mem_to_reg=0; retire; go to FETCH.
- Retire means retired increments by 1 at the clock edge leaving that state; it wraps modulo 2^CNT_W.
- Wait counter: cleared on entry to each memory state (FETCH, MEM_RD, MEM_WR) and incremented each cycle mem_ready=0. If it reaches TIMEOUT (TIMEOUT≠0), go to TRAP next cycle; no ir_we/pc_we/reg_we is issued.
- mem_ready asserted outside a memory state is ignored.
- TRAP: all strobes 0, trap=1; held until reset.
- Reset mid-access: mem_req drops asynchronously; no partial write is claimed.
- CPI with zero-wait memory:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq, j: 3

Test Plan:
- Reset low 20 ns then high, mem_ready tied 1 → state_o=0 during reset; FETCH→DECODE in 1 cycle; ir_we and pc_we pulse exactly 1 cycle; retired=0 until the first retire.
- Sequence addiu, addu, lw, sw, beq(taken, alu_zero=1), j with mem_ready=1 → state traces 0,1,10,11 / 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9; retired=6 after 23 cycles; beq asserts pc_we=1 with pc_src=01.
- beq with alu_zero=0 → pc_we=0 in BRANCH; retired still increments.
- lw with mem_ready delayed 3 cycles in MEM_RD → state stays 3 for 4 cycles; reg_we asserts only in MEM_WB.
- mem_ready held 0 in FETCH, TIMEOUT=16 → TRAP after 16 wait cycles; trap=1 and state_o=12 until reset; ir_we never asserted.
- Opcode 0x3F in DECODE → TRAP next cycle. Reset asserted mid-MEM_WR → mem_req and mem_we go 0 immediately; state_o=0.
